// File: rtl/controller_input_if.sv
// Purpose : groups the controller pins, mmio read strobes and controller words into one port bundle.
// Latency : none; this file holds wiring only.
// Backpres: none; the read strobes are single-cycle and are never stalled.
// Signals : btn_raw[15:0] raw active-low pins ([7:0] player 1, [15:8] player 2);
//           rd_p1/rd_p2 mmio read strobes; p1_word/p2_word controller words; any_press debug OR.
// Modports: master = the mmio/pin side that drives the block; slave = controller_input.
interface controller_input_if;
    logic [15:0] btn_raw;
    logic        rd_p1;
    logic        rd_p2;
    logic [31:0] p1_word;
    logic [31:0] p2_word;
    logic        any_press;

    modport master (
        output btn_raw, rd_p1, rd_p2,
        input  p1_word, p2_word, any_press
    );

    modport slave (
        input  btn_raw, rd_p1, rd_p2,
        output p1_word, p2_word, any_press
    );
endinterface

// File: rtl/controller_input.sv
// Purpose : synchronizes, debounces and tracks two 8-button controllers, with sticky press and missed-press bits.
// Latency : a clean pin change shows in the held/sticky fields 2+DEBOUNCE_CYCLES clocks later; rd clears on the next edge.
// Backpres: none; the rd_p1/rd_p2 strobes are level-sensitive and clear on every cycle they are high.
// Ports   : clock, reset_btn (async active-low) plus bus (controller_input_if.slave):
//           btn_raw in, rd_p1/rd_p2 in, p1_word/p2_word out ({15'b0, missed, sticky[7:0], held[7:0]}), any_press out.
// Option  : define CTRL_TURBO_EN for auto-repeat press events every REPEAT_CYCLES while a button is held.
module controller_input #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic               clock,
    input  logic               reset_btn,
    controller_input_if.slave  bus
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("controller_input: DEBOUNCE_CYCLES must be >= 1");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("controller_input: CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("controller_input: REPEAT_CYCLES must be >= 1");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [15:0]      s1, s2;
    logic [15:0]      stable, stable_nxt;
    logic [15:0]      sticky, sticky_nxt;
    logic [1:0]       missed, missed_nxt;
    logic             any_q;
    logic [CNT_W-1:0] cnt     [16];
    logic [CNT_W-1:0] cnt_nxt [16];
    logic [15:0]      press;
    logic [15:0]      rd_vec;

`ifdef CTRL_TURBO_EN
    localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt     [16];
    logic [RPT_W-1:0] rpt_nxt [16];
    logic [15:0]      rpt_fire;
`endif

    assign rd_vec = {{8{bus.rd_p2}}, {8{bus.rd_p1}}};

    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < 16; i++) begin
            cnt_nxt[i] = cnt[i];
            if (s2[i] == stable[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                stable_nxt[i] = s2[i];
                cnt_nxt[i]    = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

`ifdef CTRL_TURBO_EN
    // The repeat counter only starts the cycle after the initial press, so the
    // first repeat lands exactly REPEAT_CYCLES clocks after that press event.
    always_comb begin
        rpt_fire = '0;
        for (int i = 0; i < 16; i++) begin
            rpt_nxt[i] = '0;
            if (stable[i]) begin
                if (rpt[i] == RPT_LAST) begin
                    rpt_fire[i] = 1'b1;
                    rpt_nxt[i]  = '0;
                end else begin
                    rpt_nxt[i] = rpt[i] + RPT_W'(1);
                end
            end
        end
    end

    assign press = (stable_nxt & ~stable) | rpt_fire;
`else
    assign press = stable_nxt & ~stable;
`endif

    // Set wins over the read strobe for both sticky and missed bits, so a press
    // landing on the same edge as a read is never lost.
    always_comb begin
        sticky_nxt    = press | (sticky & ~rd_vec);
        missed_nxt[0] = (|(press[7:0]  & sticky[7:0]))  | (missed[0] & ~bus.rd_p1);
        missed_nxt[1] = (|(press[15:8] & sticky[15:8])) | (missed[1] & ~bus.rd_p2);
    end

    always_ff @(posedge clock or negedge reset_btn) begin
        if (!reset_btn) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            sticky <= '0;
            missed <= '0;
            any_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= '0;
`ifdef CTRL_TURBO_EN
                rpt[i] <= '0;
`endif
            end
        end else begin
            // Invert the pull-up pins so a released button is 0 from reset onward.
            s1     <= ~bus.btn_raw;
            s2     <= s1;
            stable <= stable_nxt;
            sticky <= sticky_nxt;
            missed <= missed_nxt;
            any_q  <= |sticky_nxt;
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= cnt_nxt[i];
`ifdef CTRL_TURBO_EN
                rpt[i] <= rpt_nxt[i];
`endif
            end
        end
    end

    assign bus.p1_word   = {15'b0, missed[0], sticky[7:0],  stable[7:0]};
    assign bus.p2_word   = {15'b0, missed[1], sticky[15:8], stable[15:8]};
    assign bus.any_press = any_q;

endmodule

// File: doc/controller_input.md
Name: controller_input

Overview:
- Front end for the two player controllers wired to the gpio header. Feeds the controller-read words that mmio returns to the processor.
- Per button: synchronizes the raw pins, debounces them, tracks held state, and records press events in sticky bits.
- Sticky press bits are cleared by a per-player read strobe from mmio, so the game loop never misses a short tap between polls.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable clocks required before a button change is accepted (5 ms at 50 MHz); must be >= 1.
- CNT_W, 18, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- REPEAT_CYCLES, 5000000, auto-repeat period while held; used only with CTRL_TURBO_EN.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset_btn  input  1  asynchronous, active-low reset.
- btn_raw  input  16  raw button pins, active-low (pull-ups). [7:0] is player 1, [15:8] is player 2 (gpio[15:0]).
- rd_p1  input  1  one-cycle strobe from mmio: p1_word was read; clear player-1 sticky bits.
- rd_p2  input  1  same strobe for player 2.
- p1_word  output  32  player-1 word: [7:0] held state, [15:8] sticky press, [16] missed-press flag, [31:17] zero.
- p2_word  output  32  player-2 word, same layout.
- any_press  output  1  OR of all 16 sticky press bits, for LED/debug.

Behaviour:
- Reset (asynchronous, reset_btn=0):
  - Sync flops, debounce counters, stable state, sticky bits and missed flags all go to 0.
  - p1_word=0, p2_word=0, any_press=0.
  - Released buttons read as 0 after inversion, so there is no spurious press on reset release.
- Input path, per bit:
  - raw is inverted to active-high, then passed through a 2-flop synchronizer (s1 -> s2).
- Debounce, per bit:
  - If s2 == stable, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, stable <= s2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES clocks at s2 resets the count and never reaches stable.
- Latency: a clean raw transition present before rising edge 1 appears in the held-state field after edge 2+DEBOUNCE_CYCLES.
- Press event: a 0->1 transition of stable, registered in the same cycle stable updates.
  - The sticky press bit and the state bit become visible on the same edge.
  - Release (1->0) clears the state bit only; the sticky bit is kept.
- Sticky press bit: set by a press event, cleared by that player's rd strobe.
- Simultaneous press event and rd on the same edge: set wins.
  - Bit reads 1 afterwards.
  - The missed flag is not set.
- Missed flag [16]:
  - Set when a press event hits a sticky bit that is already 1.
  - Cleared by rd unless a new missed condition occurs on the same edge (set wins).
- rd strobes:
  - Level-sensitive per cycle: each cycle high clears.
  - rd_p1 never affects player 2, and rd_p2 never affects player 1.
- Outputs are registered, with no combinational path from rd or btn_raw to any output.
- any_press is registered from the next-state sticky bits, so it updates on the same edge as the words.
- Mid-debounce reset: counters clear. After release the bench must see the full 2+DEBOUNCE_CYCLES latency again.

Optional Feature:
- CTRL_TURBO_EN defined:
  - Each bit gets a repeat counter that runs while stable==1 and clears when stable==0.
  - When it reaches REPEAT_CYCLES-1, it generates a press event (same sticky/missed rules) and wraps to 0.
  - The first repeat occurs REPEAT_CYCLES clocks after the initial press event.
- CTRL_TURBO_EN undefined:
  - No repeat counters are instantiated.
  - Only 0->1 transitions generate press events.

Test Plan:
- DEBOUNCE_CYCLES=4: drive btn_raw[0] low from edge 1 and hold. p1_word[0] and [8] are 0 through edge 5, both 1 after edge 6; any_press=1.
- DEBOUNCE_CYCLES=4: pulse btn_raw[3] low for 3 clocks, then high. p1_word stays 0x00000000 indefinitely.
- Player 2 pressed and debounced (p2_word=0x00000101), then one-cycle rd_p2. Result is p2_word=0x00000001 (held, sticky cleared) and p1_word is unchanged.
- Press, release, press on btn_raw[9] without rd_p2. p2_word[16]=1, [9]=1. Then rd_p2 gives p2_word[16:8]=0.
- Debounced press lands on the same edge as rd_p1 high. p1_word[8]=1 and [16]=0 after that edge.
- Hold btn_raw[2] low with the counter partway, assert reset_btn=0 for 2 cycles. All outputs are 0 immediately (asynchronous). After release, the state is set only after edge 2+DEBOUNCE_CYCLES.
- With CTRL_TURBO_EN and REPEAT_CYCLES=8: hold button 1, clear via rd_p1 after the first press. The sticky bit re-sets exactly 8 clocks after the initial event.
